pwl_cmd_sequencer: RTL and testbench
====================================

Name: pwl_cmd_sequencer

Overview:
- Upstream feeder for the PWL synth command port: queues {cmd, wdata} requests and issues them one at a time as single-cycle 3-bit cmd / 13-bit wdata words.
- Enforces a minimum spacing between commands.
- For read-type commands, waits for the synth's data_ready/data_out reply and returns it on a response port.
- A timeout guarantees forward progress.

Parameters:
- DEPTH, 4: command queue depth in entries, power of two, at least 2.
- GAP, 1: idle cycles (cmd_out=0) inserted after each issued command, or after each completed response for reads; 0 allowed.
- READ_CMD, 3'd1: opcode that requires a response.
- TIMEOUT, 15: maximum WAIT_RSP cycles before a timeout response; at least 1.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- req_valid  input  1  request valid
- req_ready  output  1  queue can accept a request (= !full)
- req_cmd  input  3  request opcode (0 = NOP)
- req_wdata  input  13  request data
- cmd_out  output  3  command to synth; 0 when not issuing
- wdata_out  output  13  data to synth, qualified by cmd_out != 0
- data_in  input  13  synth read data
- data_ready_in  input  1  synth read data valid
- rsp_valid  output  1  one-cycle response pulse
- rsp_data  output  13  response data; 0 on timeout
- rsp_timeout  output  1  response is a timeout; qualified by rsp_valid
- busy  output  1  FSM not IDLE, or queue non-empty

Behaviour:
Reset
- Async assert immediately clears the queue, FSM (-> IDLE), counters and all registered outputs: cmd_out=0, wdata_out=0, rsp_valid=0, rsp_data=0, rsp_timeout=0.
- During reset: req_ready=0, busy=0. req_ready=1 from the first edge after release.
- Reset mid-operation discards queued and in-flight commands; no response is produced.

Queue
- FIFO, DEPTH entries, in-order.
- Push on edge with req_valid & req_ready.
- req_ready depends only on registered occupancy; a same-cycle pop never admits a push when full.
- Push and pop on the same edge: occupancy unchanged.
- Pointers wrap modulo DEPTH.
- NOP (cmd 0) entries are queued and consume a slot; cmd_out stays 0 for that slot.

FSM states: IDLE, ISSUE, GAP, WAIT_RSP.
- IDLE: if queue non-empty, pop the head on this edge -> ISSUE. cmd_out/wdata_out are registered from the popped entry.
- ISSUE (exactly 1 cycle): cmd_out/wdata_out hold the command.
  - If cmd == READ_CMD -> WAIT_RSP.
  - Else, if GAP > 0 -> GAP.
  - Else, if queue non-empty, pop the next entry and stay in ISSUE (back-to-back).
  - Else -> IDLE.
  - On leaving ISSUE, cmd_out returns to 0; wdata_out holds its last value.
- GAP: counts GAP cycles, then behaves as IDLE (pop if non-empty).
  - Issue spacing with a fed queue: GAP+1 cycles.
- WAIT_RSP: cycle counter starts at 1 on entry.
  - data_ready_in=1: capture data_in into rsp_data, rsp_timeout=0, pulse rsp_valid the next cycle -> GAP (or IDLE/issue if GAP=0).
  - Counter == TIMEOUT with data_ready_in=0: rsp_data=0, rsp_timeout=1, pulse rsp_valid -> GAP.
  - data_ready_in and timeout in the same cycle: data wins.
- data_ready_in outside WAIT_RSP, including during ISSUE, is ignored.

Timing
- Latency, empty queue and IDLE: request accepted on edge k -> cmd_out valid in the cycle after edge k+1.
- Exactly one outstanding read at a time; no command issues while in WAIT_RSP.
- No width arithmetic beyond counters: GAP counter is clog2(GAP+1) bits, timeout counter is clog2(TIMEOUT+1) bits; both saturate safely.

Test Plan:
- Single write: push cmd=3, wdata=0x1ABC into empty idle block -> cmd_out=3, wdata_out=0x1ABC for exactly one cycle, in the cycle after edge k+1; then cmd_out=0; rsp_valid never asserted; busy falls after the GAP cycles.
- Burst (DEPTH=4, GAP=1): push 7 writes (cmd=2, wdata=1..7) back-to-back -> req_ready drops while 4 entries are held; cmd_out asserted every 2nd cycle; wdata_out sequence 1..7 in order, no loss or duplication.
- Read reply: push cmd=1 then write cmd=2, wdata=0x0055; drive data_ready_in=1, data_in=0x0123 on the 3rd WAIT_RSP cycle -> rsp_valid pulse with rsp_data=0x0123, rsp_timeout=0; the write issues GAP=1 cycle after WAIT_RSP exits.
- Read timeout: push cmd=1, keep data_ready_in=0 -> after 15 WAIT_RSP cycles, rsp_valid=1, rsp_timeout=1, rsp_data=0; a queued write issues afterwards. Also: data_ready_in on cycle 15 -> data response, not timeout.
- Spurious data_ready: pulse data_ready_in with data_in=0x1FFF during IDLE and during a write's ISSUE/GAP -> no rsp_valid.
- Async reset: assert rst mid-WAIT_RSP with 2 entries queued -> cmd_out, rsp_valid and busy go 0 without a clock edge; after release nothing issues and req_ready=1.

Source files
------------

// File: rtl/pwl_cmd_sequencer.sv
// Command sequencer for the PWL synth: queues {cmd, wdata} requests, issues them one per
// slot with a fixed idle gap, and collects read replies (or times out) on a response port.
module pwl_cmd_sequencer #(
    parameter int         DEPTH    = 4,
    parameter int         GAP      = 1,
    parameter logic [2:0] READ_CMD = 3'd1,
    parameter int         TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_cmd,
    input  logic [12:0] req_wdata,
    output logic [2:0]  cmd_out,
    output logic [12:0] wdata_out,
    input  logic [12:0] data_in,
    input  logic        data_ready_in,
    output logic        rsp_valid,
    output logic [12:0] rsp_data,
    output logic        rsp_timeout,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_GAP,
        S_WAIT_RSP
    } state_t;

    state_t state_q, state_d;

    // Request handshake: a request transfers on the rising edge where req_valid and
    // req_ready are both high. req_ready comes only from registered occupancy, so it is
    // stable for the whole cycle and a pop on the same edge never frees a slot early.
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          ready_en_q;
    logic          full, empty, push, pop;
    logic [2:0]    head_cmd;
    logic [12:0]   head_wdata;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign req_ready = ready_en_q & ~full;
    assign push      = req_valid & req_ready;
    assign {head_cmd, head_wdata} = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {req_cmd, req_wdata};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          rsp_fire, rsp_is_tmo;
    logic          slot_done, take_next;

    // slot_done: the current command (or its reply) is finished and the gap starts.
    // take_next: behave as IDLE, i.e. pop the head if there is one.
    always_comb begin
        state_d    = state_q;
        gap_cnt_d  = gap_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        pop        = 1'b0;
        rsp_fire   = 1'b0;
        rsp_is_tmo = 1'b0;
        slot_done  = 1'b0;
        take_next  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                take_next = 1'b1;
            end
            S_ISSUE: begin
                if (cmd_out == READ_CMD) begin
                    state_d   = S_WAIT_RSP;
                    tmo_cnt_d = TW'(1);
                end else begin
                    slot_done = 1'b1;
                end
            end
            S_GAP: begin
                if (gap_cnt_q >= GAP_LAST) begin
                    take_next = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            S_WAIT_RSP: begin
                // Data beats the timeout when both land in the same cycle.
                if (data_ready_in) begin
                    rsp_fire  = 1'b1;
                    slot_done = 1'b1;
                end else if (tmo_cnt_q >= TMO_LAST) begin
                    rsp_fire   = 1'b1;
                    rsp_is_tmo = 1'b1;
                    slot_done  = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (slot_done) begin
            if (GAP > 0) begin
                state_d   = S_GAP;
                gap_cnt_d = GW'(1);
            end else begin
                take_next = 1'b1;
            end
        end

        if (take_next) begin
            if (!empty) begin
                pop     = 1'b1;
                state_d = S_ISSUE;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            gap_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            cmd_out     <= '0;
            wdata_out   <= '0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            cmd_out   <= pop ? head_cmd : 3'd0;
            if (pop) begin
                wdata_out <= head_wdata;
            end
            rsp_valid <= rsp_fire;
            if (rsp_fire) begin
                rsp_data    <= rsp_is_tmo ? 13'd0 : data_in;
                rsp_timeout <= rsp_is_tmo;
            end
        end
    end

    assign busy = (state_q != S_IDLE) | ~empty;

endmodule

// File: tb/tb_pwl_cmd_sequencer.sv
// Bench for pwl_cmd_sequencer: directed timing scenarios followed by a randomized run
// checked against a transaction-level model (expected issue queue plus reply schedule).
module tb_pwl_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_cmd = 3'd0;
    logic [12:0] req_wdata = 13'd0;
    logic [2:0]  cmd_out;
    logic [12:0] wdata_out;
    logic [12:0] data_in = 13'd0;
    logic        data_ready_in = 1'b0;
    logic        rsp_valid;
    logic [12:0] rsp_data;
    logic        rsp_timeout;
    logic        busy;

    int n_cmp = 0;
    int n_fail = 0;
    int unsigned cyc = 0;

    logic [15:0] exp_q[$];

    pwl_cmd_sequencer #(
        .DEPTH(4), .GAP(1), .READ_CMD(3'd1), .TIMEOUT(15)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_cmd(req_cmd),
        .req_wdata(req_wdata),
        .cmd_out(cmd_out),
        .wdata_out(wdata_out),
        .data_in(data_in),
        .data_ready_in(data_ready_in),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .rsp_timeout(rsp_timeout),
        .busy(busy)
    );

    // clock / cycle stamp
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic v, input logic [2:0] c, input logic [12:0] d);
        req_valid = v;
        req_cmd   = c;
        req_wdata = d;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, busy, 0);
    endtask

    initial begin
        int unsigned seen_wd[$];
        int unsigned seen_cyc[$];
        int          idx;
        bit          saw_full;
        logic        pending;
        bit          have_last;
        int unsigned last_iss, iss_cyc, rd_delay, exp_rsp_cyc;
        logic [12:0] rd_data;
        logic        exp_v, exp_to;
        int          r;

        // ---- reset state ----
        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_out", cmd_out, 0);
        check("rst_wdata_out", wdata_out, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_timeout", rsp_timeout, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", req_ready, 1);

        // ---- single write, spurious data_ready in IDLE / ISSUE / GAP ----
        drive_req(1'b1, 3'd3, 13'h1ABC);
        data_ready_in = 1'b1;
        data_in = 13'h1FFF;
        @(negedge clk);
        drive_req(1'b0, 3'd0, 13'd0);
        data_ready_in = 1'b0;
        check("wr_cmd_not_yet", cmd_out, 0);
        check("wr_busy_queued", busy, 1);
        @(negedge clk);
        check("wr_cmd", cmd_out, 3);
        check("wr_wdata", wdata_out, 13'h1ABC);
        check("wr_rsp_idle0", rsp_valid, 0);
        data_ready_in = 1'b1;
        @(negedge clk);
        check("wr_cmd_cleared", cmd_out, 0);
        check("wr_wdata_held", wdata_out, 13'h1ABC);
        check("wr_busy_gap", busy, 1);
        check("wr_rsp_idle1", rsp_valid, 0);
        @(negedge clk);
        data_ready_in = 1'b0;
        check("wr_busy_done", busy, 0);
        check("wr_rsp_idle2", rsp_valid, 0);
        @(negedge clk);
        check("wr_rsp_idle3", rsp_valid, 0);

        // ---- burst of 7 writes ----
        idx = 0;
        saw_full = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (cmd_out != 0) begin
                check("burst_cmd", cmd_out, 2);
                seen_wd.push_back(wdata_out);
                seen_cyc.push_back(cyc);
            end
            if (!req_ready) saw_full = 1;
            if (idx < 7) begin
                drive_req(1'b1, 3'd2, 13'(idx + 1));
                if (req_ready) idx++;
            end else begin
                drive_req(1'b0, 3'd0, 13'd0);
            end
            if (idx == 7 && !busy) break;
        end
        check("burst_saw_full", saw_full, 1);
        check("burst_count", seen_wd.size(), 7);
        for (int i = 0; i < seen_wd.size(); i++) begin
            check("burst_order", seen_wd[i], i + 1);
            if (i > 0) check("burst_spacing", seen_cyc[i] - seen_cyc[i-1], 2);
        end
        wait_idle("burst_idle");

        // ---- read with data reply on 3rd WAIT_RSP cycle ----
        @(negedge clk);
        drive_req(1'b1, 3'd1, 13'h00AA);
        @(negedge clk);
        drive_req(1'b1, 3'd2, 13'h0055);
        @(negedge clk);
        drive_req(1'b0, 3'd0, 13'd0);
        check("rd_cmd", cmd_out, 1);
        check("rd_wdata", wdata_out, 13'h00AA);
        @(negedge clk);
        check("rd_w1_hold", cmd_out, 0);
        @(negedge clk);
        check("rd_w2_hold", cmd_out, 0);
        check("rd_w2_rsp", rsp_valid, 0);
        @(negedge clk);
        check("rd_w3_hold", cmd_out, 0);
        data_ready_in = 1'b1;
        data_in = 13'h0123;
        @(negedge clk);
        data_ready_in = 1'b0;
        check("rd_rsp_valid", rsp_valid, 1);
        check("rd_rsp_data", rsp_data, 13'h0123);
        check("rd_rsp_timeout", rsp_timeout, 0);
        check("rd_gap_cmd", cmd_out, 0);
        @(negedge clk);
        check("rd_next_cmd", cmd_out, 2);
        check("rd_next_wdata", wdata_out, 13'h0055);
        check("rd_rsp_pulse", rsp_valid, 0);
        wait_idle("rd_idle");

        // ---- read timeout, then queued write ----
        @(negedge clk);
        drive_req(1'b1, 3'd1, 13'h0001);
        @(negedge clk);
        drive_req(1'b1, 3'd2, 13'h0777);
        @(negedge clk);
        drive_req(1'b0, 3'd0, 13'd0);
        check("to_cmd", cmd_out, 1);
        for (int n = 1; n <= 15; n++) begin
            @(negedge clk);
            check("to_wait_rsp", rsp_valid, 0);
            check("to_wait_cmd", cmd_out, 0);
        end
        @(negedge clk);
        check("to_rsp_valid", rsp_valid, 1);
        check("to_rsp_timeout", rsp_timeout, 1);
        check("to_rsp_data", rsp_data, 0);
        @(negedge clk);
        check("to_next_cmd", cmd_out, 2);
        check("to_next_wdata", wdata_out, 13'h0777);
        wait_idle("to_idle");

        // ---- data on the 15th WAIT_RSP cycle wins over timeout ----
        @(negedge clk);
        drive_req(1'b1, 3'd1, 13'h0002);
        @(negedge clk);
        drive_req(1'b0, 3'd0, 13'd0);
        @(negedge clk);
        check("edge_cmd", cmd_out, 1);
        for (int n = 1; n <= 15; n++) begin
            @(negedge clk);
            check("edge_wait_rsp", rsp_valid, 0);
            if (n == 15) begin
                data_ready_in = 1'b1;
                data_in = 13'h0F0F;
            end
        end
        @(negedge clk);
        data_ready_in = 1'b0;
        check("edge_rsp_valid", rsp_valid, 1);
        check("edge_rsp_timeout", rsp_timeout, 0);
        check("edge_rsp_data", rsp_data, 13'h0F0F);
        wait_idle("edge_idle");

        // ---- async reset mid WAIT_RSP with two entries queued ----
        @(negedge clk);
        drive_req(1'b1, 3'd1, 13'h0003);
        @(negedge clk);
        drive_req(1'b1, 3'd4, 13'h0100);
        @(negedge clk);
        drive_req(1'b1, 3'd5, 13'h0200);
        @(negedge clk);
        drive_req(1'b0, 3'd0, 13'd0);
        check("ar_busy_before", busy, 1);
        check("ar_full_before", req_ready, 1);
        #1 rst = 1'b1;
        #1;
        check("ar_cmd_out", cmd_out, 0);
        check("ar_rsp_valid", rsp_valid, 0);
        check("ar_busy", busy, 0);
        check("ar_req_ready", req_ready, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            check("ar_no_cmd", cmd_out, 0);
            check("ar_no_rsp", rsp_valid, 0);
        end
        check("ar_req_ready_after", req_ready, 1);
        check("ar_busy_after", busy, 0);

        // ---- randomized traffic against the transaction model ----
        pending = 0;
        have_last = 0;
        last_iss = 0;
        iss_cyc = 0;
        rd_delay = 0;
        exp_rsp_cyc = 0;
        rd_data = 13'd0;
        exp_q.delete();
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            exp_v = pending && (cyc == exp_rsp_cyc);
            check("rnd_rsp_valid", rsp_valid, exp_v);
            if (exp_v) begin
                exp_to = (rd_delay > 15);
                check("rnd_rsp_timeout", rsp_timeout, exp_to);
                check("rnd_rsp_data", rsp_data, exp_to ? 13'd0 : rd_data);
            end
            if (pending && cyc >= exp_rsp_cyc) pending = 0;

            if (cmd_out != 0) begin
                check("rnd_issue_in_wait", pending, 0);
                if (have_last) check("rnd_spacing", (cyc - last_iss) >= 2, 1);
                have_last = 1;
                last_iss = cyc;
                if (exp_q.size() > 0) check("rnd_issue", {cmd_out, wdata_out}, exp_q.pop_front());
                else check("rnd_issue_extra", cmd_out, 0);
                if (cmd_out == 3'd1) begin
                    pending = 1;
                    iss_cyc = cyc;
                    rd_delay = $urandom_range(1, 18);
                    rd_data = 13'($urandom);
                    exp_rsp_cyc = iss_cyc + ((rd_delay <= 15) ? rd_delay : 15) + 1;
                end
            end

            // synth reply: exact pulse for the read in flight, occasional spurious ones otherwise
            if (pending && (cyc - iss_cyc) == rd_delay) begin
                data_ready_in = 1'b1;
                data_in = rd_data;
            end else if (!pending && $urandom_range(0, 7) == 0) begin
                data_ready_in = 1'b1;
                data_in = 13'($urandom);
            end else begin
                data_ready_in = 1'b0;
                data_in = 13'($urandom);
            end

            if (i < 600 && $urandom_range(0, 2) != 0) begin
                r = $urandom_range(0, 7);
                if (r == 0) drive_req(1'b1, 3'd0, 13'($urandom));
                else if (r <= 2) drive_req(1'b1, 3'd1, 13'($urandom));
                else drive_req(1'b1, 3'($urandom_range(2, 7)), 13'($urandom));
                if (req_ready && req_cmd != 0) exp_q.push_back({req_cmd, req_wdata});
            end else begin
                drive_req(1'b0, 3'd0, 13'd0);
            end

            if (i >= 600 && exp_q.size() == 0 && !pending && !busy) break;
        end
        data_ready_in = 1'b0;
        check("rnd_drain_q", exp_q.size(), 0);
        check("rnd_pending_end", pending, 0);
        check("rnd_busy_end", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
